// File: rtl/pipeline_perf_monitor.sv
// pipeline_perf_monitor: run-state sequencer, saturating cycle/retire/event counters and retired-instruction trace FIFO
module pipeline_perf_monitor #(
    parameter int CNT_WIDTH    = 32,
    parameter int NUM_EVENTS   = 4,
    parameter int TRACE_DEPTH  = 8,
    parameter int PC_WIDTH     = 64,
    parameter int DRAIN_CYCLES = 5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             start,
    input  logic                             end_program,
    input  logic                             retire_valid,
    input  logic [PC_WIDTH-1:0]              retire_pc,
    input  logic [31:0]                      retire_instr,
    input  logic [NUM_EVENTS-1:0]            event_in,
    output logic [CNT_WIDTH-1:0]             cycle_count,
    output logic [CNT_WIDTH-1:0]             retired_count,
    output logic [NUM_EVENTS*CNT_WIDTH-1:0]  event_counts,
    output logic                             running,
    output logic                             done,
    input  logic                             trace_rd_en,
    output logic                             trace_valid,
    output logic [PC_WIDTH-1:0]              trace_pc,
    output logic [31:0]                      trace_instr,
    output logic [$clog2(TRACE_DEPTH):0]     trace_level,
    output logic                             trace_overflow
);
    localparam int AW = $clog2(TRACE_DEPTH);
    localparam int DW = DRAIN_CYCLES < 2 ? 1 : $clog2(DRAIN_CYCLES);
    localparam logic [AW:0] FULL = (AW+1)'(TRACE_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

    state_t                              state;
    logic [DW-1:0]                       drain;
    logic                                active, wr, do_rd, do_wr;
    logic [AW-1:0]                       rd_ptr, wr_ptr;
    logic [AW:0]                         count;
    logic [PC_WIDTH+31:0]                mem [TRACE_DEPTH];
    logic [NUM_EVENTS-1:0][CNT_WIDTH-1:0] ev_cnt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic en);
        return (en && c != '1) ? c + CNT_WIDTH'(1) : c;
    endfunction

    // a cycle counts when the state before the edge is RUN or DRAIN; clear suppresses the trace write
    assign active = state == RUN || state == DRAIN;
    assign wr     = active && retire_valid && !clear;
    assign do_rd  = trace_rd_en && count != '0;
    assign do_wr  = wr && (count != FULL || do_rd);

    assign trace_valid  = count != '0;
    assign trace_level  = count;
    assign {trace_pc, trace_instr} = trace_valid ? mem[rd_ptr] : '0;
    assign event_counts = ev_cnt;

    // run sequencer with registered running/done flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            drain   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (clear) begin
            state   <= IDLE;
            drain   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= RUN;
                    running <= 1'b1;
                end
                RUN: if (end_program) begin
                    if (DRAIN_CYCLES == 0) begin
                        state   <= HALTED;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state <= DRAIN;
                        drain <= DW'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: if (drain == '0) begin
                    state   <= HALTED;
                    running <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    drain <= drain - DW'(1);
                end
                default: ;
            endcase
        end
    end

    // saturating counters advance only on active cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count   <= '0;
            retired_count <= '0;
            ev_cnt        <= '0;
        end else if (clear) begin
            cycle_count   <= '0;
            retired_count <= '0;
            ev_cnt        <= '0;
        end else if (active) begin
            cycle_count   <= sat_inc(cycle_count, 1'b1);
            retired_count <= sat_inc(retired_count, retire_valid);
            for (int k = 0; k < NUM_EVENTS; k++)
                ev_cnt[k] <= sat_inc(ev_cnt[k], event_in[k]);
        end
    end

    // trace pointers, occupancy and sticky overflow; a write into a full FIFO is dropped unless a pop frees the slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            trace_overflow <= 1'b0;
        end else if (clear) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            trace_overflow <= 1'b0;
        end else begin
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
            if (wr && !do_wr) trace_overflow <= 1'b1;
        end
    end

    // trace storage needs no reset: the head is masked to zero while empty
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= {retire_pc, retire_instr};
    end
endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// tb_pipeline_perf_monitor: random and directed stimulus checked against a queue/integer model of two monitor configurations
module tb_pipeline_perf_monitor;
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_HALT = 3;

    logic        clk = 0, reset = 1, clear = 0, start = 0, end_program = 0;
    logic        retire_valid = 0, trace_rd_en = 0;
    logic [63:0] retire_pc = 0;
    logic [31:0] retire_instr = 0;
    logic [3:0]  event_in = 0;

    logic [31:0]  cyc0, ret0;
    logic [127:0] ev0;
    logic         run0, done0, tv0, ovf0;
    logic [63:0]  pc0;
    logic [31:0]  ins0;
    logic [3:0]   lvl0;

    logic [3:0]   cyc1, ret1;
    logic [15:0]  ev1;
    logic         run1, done1, tv1, ovf1;
    logic [63:0]  pc1;
    logic [31:0]  ins1;
    logic [3:0]   lvl1;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    pipeline_perf_monitor dut0 (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .end_program(end_program),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
        .event_in(event_in), .cycle_count(cyc0), .retired_count(ret0), .event_counts(ev0),
        .running(run0), .done(done0), .trace_rd_en(trace_rd_en), .trace_valid(tv0),
        .trace_pc(pc0), .trace_instr(ins0), .trace_level(lvl0), .trace_overflow(ovf0)
    );

    pipeline_perf_monitor #(.CNT_WIDTH(4), .DRAIN_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .end_program(end_program),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
        .event_in(event_in), .cycle_count(cyc1), .retired_count(ret1), .event_counts(ev1),
        .running(run1), .done(done1), .trace_rd_en(trace_rd_en), .trace_valid(tv1),
        .trace_pc(pc1), .trace_instr(ins1), .trace_level(lvl1), .trace_overflow(ovf1)
    );

    function automatic int cw(input int i);
        return i == 0 ? 32 : 4;
    endfunction

    function automatic int dc(input int i);
        return i == 0 ? 5 : 0;
    endfunction

    function automatic longint sat(input longint v, input int i);
        return v < (longint'(1) << cw(i)) - 1 ? v + 1 : v;
    endfunction

    int          ph [2];
    int          left [2];
    longint      m_cyc [2];
    longint      m_ret [2];
    longint      m_ev [2][4];
    logic [95:0] q [$];
    bit          m_ovf;

    always @(posedge clk or negedge reset) begin
        bit rd, room, act;
        if (!reset || clear) begin
            for (int i = 0; i < 2; i++) begin
                ph[i] = P_IDLE; left[i] = 0; m_cyc[i] = 0; m_ret[i] = 0;
                for (int k = 0; k < 4; k++) m_ev[i][k] = 0;
            end
            q.delete();
            m_ovf = 0;
        end else begin
            rd   = trace_rd_en && q.size() > 0;
            room = q.size() < 8 || rd;
            if (rd) q.delete(0);
            for (int i = 0; i < 2; i++) begin
                act = ph[i] == P_RUN || ph[i] == P_DRAIN;
                if (act) begin
                    m_cyc[i] = sat(m_cyc[i], i);
                    if (retire_valid) m_ret[i] = sat(m_ret[i], i);
                    for (int k = 0; k < 4; k++) if (event_in[k]) m_ev[i][k] = sat(m_ev[i][k], i);
                    if (i == 0 && retire_valid) begin
                        if (room) q.push_back({retire_pc, retire_instr});
                        else m_ovf = 1;
                    end
                end
                if (ph[i] == P_IDLE && start) ph[i] = P_RUN;
                else if (ph[i] == P_RUN && end_program) begin
                    if (dc(i) == 0) ph[i] = P_HALT;
                    else begin ph[i] = P_DRAIN; left[i] = dc(i); end
                end else if (ph[i] == P_DRAIN) begin
                    left[i] = left[i] - 1;
                    if (left[i] == 0) ph[i] = P_HALT;
                end
            end
        end
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic compare();
        logic [63:0] hpc;
        logic [31:0] hin;
        hpc = q.size() > 0 ? q[0][95:32] : 64'h0;
        hin = q.size() > 0 ? q[0][31:0] : 32'h0;
        chk("cyc0", cyc0, m_cyc[0]);
        chk("ret0", ret0, m_ret[0]);
        chk("run0", run0, ph[0] == P_RUN || ph[0] == P_DRAIN);
        chk("done0", done0, ph[0] == P_HALT);
        chk("cyc1", cyc1, m_cyc[1]);
        chk("ret1", ret1, m_ret[1]);
        chk("run1", run1, ph[1] == P_RUN || ph[1] == P_DRAIN);
        chk("done1", done1, ph[1] == P_HALT);
        for (int k = 0; k < 4; k++) begin
            chk("ev0", ev0[k*32 +: 32], m_ev[0][k]);
            chk("ev1", ev1[k*4 +: 4], m_ev[1][k]);
        end
        chk("tvalid", tv0, q.size() > 0);
        chk("tlevel", lvl0, q.size());
        chk("tpc", pc0, hpc);
        chk("tinstr", ins0, hin);
        chk("tovf", ovf0, m_ovf);
    endtask

    initial begin
        #3;
        forever begin
            @(negedge clk);
            compare();
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1 reset = 0;
        tick(); tick();
        reset = 1;
        tick();
        chk("rst_cyc", cyc0, 0);
        chk("rst_lvl", lvl0, 0);
        chk("rst_run", run0, 0);
        chk("rst_done", done0, 0);

        event_in = 4'b1011;
        tick(); tick();
        event_in = 0;
        start = 1; tick(); start = 0;
        for (int i = 0; i < 10; i++) begin
            retire_valid = i < 6;
            retire_pc    = 64'(i * 4);
            retire_instr = 32'h1000_0000 + i;
            event_in     = i < 3 ? 4'b1011 : 4'b0000;
            end_program  = i == 9;
            tick();
        end
        retire_valid = 0; end_program = 0; event_in = 0;
        chk("halt1_done", done1, 1);
        chk("halt1_cyc", cyc1, 10);
        repeat (4) tick();
        chk("drain_run", run0, 1);
        tick();
        chk("halt_done", done0, 1);
        chk("halt_run", run0, 0);
        chk("halt_cyc", cyc0, 15);
        chk("ret6", ret0, 6);
        chk("ev_ch0", ev0[31:0], 3);
        chk("ev_ch1", ev0[63:32], 3);
        chk("ev_ch2", ev0[95:64], 0);
        chk("ev_ch3", ev0[127:96], 3);
        repeat (3) tick();
        chk("hold_cyc", cyc0, 15);

        trace_rd_en = 1;
        for (int i = 0; i < 6; i++) begin
            chk("pop_pc", pc0, 64'(i * 4));
            chk("pop_instr", ins0, 32'h1000_0000 + i);
            tick();
        end
        trace_rd_en = 0;
        chk("pop_empty", tv0, 0);
        chk("pop_ovf", ovf0, 0);

        clear = 1; start = 1; tick(); clear = 0; start = 0;
        chk("clr_run", run0, 0);
        chk("clr_done", done0, 0);
        chk("clr_cyc", cyc0, 0);
        tick();
        chk("clr_idle", cyc0, 0);

        start = 1; tick(); start = 0;
        retire_valid = 1;
        for (int i = 0; i < 8; i++) begin
            retire_pc = 64'h100 + 64'(i);
            retire_instr = 32'h2000_0000 + i;
            tick();
        end
        retire_valid = 0;
        chk("full_lvl", lvl0, 8);
        chk("full_ovf", ovf0, 0);
        retire_valid = 1; trace_rd_en = 1;
        retire_pc = 64'h200; retire_instr = 32'h2000_0100;
        tick();
        trace_rd_en = 0;
        chk("rw_lvl", lvl0, 8);
        chk("rw_ovf", ovf0, 0);
        chk("rw_head", pc0, 64'h101);
        retire_pc = 64'h300; tick();
        retire_pc = 64'h301; tick();
        retire_valid = 0;
        chk("ovf_set", ovf0, 1);
        chk("ovf_lvl", lvl0, 8);
        chk("ovf_ret", ret0, 11);
        trace_rd_en = 1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf_pop", pc0, i < 7 ? 64'h101 + 64'(i) : 64'h200);
            tick();
        end
        trace_rd_en = 0;
        chk("ovf_empty", tv0, 0);
        chk("ovf_sticky", ovf0, 1);
        repeat (3) tick();
        chk("sat_cyc1", cyc1, 15);
        chk("sat_ret1", ret1, 11);

        end_program = 1; tick(); end_program = 0;
        tick();
        chk("mid_drain", run0, 1);
        reset = 0;
        #1;
        chk("async_cyc", cyc0, 0);
        chk("async_ret", ret0, 0);
        chk("async_run", run0, 0);
        chk("async_ev", ev0, 0);
        chk("async_lvl", lvl0, 0);
        chk("async_ovf", ovf0, 0);
        chk("async_pc", pc0, 0);
        tick();
        reset = 1;
        tick();

        for (int n = 0; n < 3000; n++) begin
            start        = $urandom_range(0, 9) == 0;
            end_program  = $urandom_range(0, 29) == 0;
            retire_valid = $urandom_range(0, 1) == 1;
            retire_pc    = {$urandom, $urandom};
            retire_instr = $urandom;
            event_in     = 4'($urandom);
            trace_rd_en  = $urandom_range(0, 9) < 4;
            clear        = $urandom_range(0, 199) == 0;
            tick();
        end
        {start, end_program, retire_valid, trace_rd_en, clear} = '0;
        event_in = 0;
        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
